// File: rtl/code_sched_pkg.sv
// Shared constants and FSM encoding for the code_sched scheduler.
// The CLR state exists only when CODE_SCHED_CLEAR_EN is defined.
package code_sched_pkg;

    localparam int DATA_W_DEF = 64;
    localparam int CNT_W_DEF  = 8;

    localparam logic CLIENT0 = 1'b0;
    localparam logic CLIENT1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
`ifdef CODE_SCHED_CLEAR_EN
        , CLR = 2'd3
`endif
    } state_t;

endpackage

// File: rtl/code_sched_if.sv
// Client-side handshake bundle of code_sched: two request/count pairs in,
// two acknowledge pulses, the captured result and the busy flag out.
interface code_sched_if #(
    parameter int DATA_W = code_sched_pkg::DATA_W_DEF,
    parameter int CNT_W  = code_sched_pkg::CNT_W_DEF
) ();

    logic              Req0, Req1;
    logic [CNT_W-1:0]  Cnt0, Cnt1;
    logic              Ack0, Ack1;
    logic [DATA_W-1:0] Result;
    logic              Busy;

    modport master (
        output Req0, Req1, Cnt0, Cnt1,
        input  Ack0, Ack1, Result, Busy
    );

    modport slave (
        input  Req0, Req1, Cnt0, Cnt1,
        output Ack0, Ack1, Result, Busy
    );

endinterface

// File: rtl/code_sched_rr_arb2.sv
// Two-way round-robin picker: masks requests with the eligibility vector and,
// on contention, grants the client that did not win last time.
module rr_arb2
    import code_sched_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic [1:0] elig,
    output logic       gnt_valid,
    output logic       gnt_id
);

    logic [1:0] cand;

    always_comb begin
        cand      = req & elig;
        gnt_valid = |cand;
        if (cand == 2'b11) gnt_id = ~last;
        else               gnt_id = cand[1] ? CLIENT1 : CLIENT0;
    end

endmodule

// File: rtl/code_sched.sv
// Two-client scheduler for the dual-sequence generator: grants round-robin,
// steps the generator Cnt times, then returns its output with an Ack pulse.
// Optional macro CODE_SCHED_CLEAR_EN inserts a generator-clear cycle per job.
module code_sched
    import code_sched_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              Clk,
    input  logic              Reset,
    code_sched_if.slave       bus,
    output logic              Gen_Slt,
    output logic              Gen_En,
    output logic              Gen_Reset,
    input  logic [DATA_W-1:0] Gen_Out0,
    input  logic [DATA_W-1:0] Gen_Out1
);

    state_t           state;
    logic [CNT_W-1:0] rem;
    logic             last;
    logic [1:0]       elig;
    logic             gnt_valid;
    logic             gnt_id;
    logic [CNT_W-1:0] gnt_cnt;

    // A client acknowledged this cycle may not win again until Ack drops.
    assign elig    = ~{bus.Ack1, bus.Ack0};
    assign gnt_cnt = (gnt_id == CLIENT1) ? bus.Cnt1 : bus.Cnt0;

    rr_arb2 u_arb (
        .req       ({bus.Req1, bus.Req0}),
        .last      (last),
        .elig      (elig),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

`ifndef CODE_SCHED_CLEAR_EN
    assign Gen_Reset = 1'b0;
`endif

    // NOTE: every register here is assigned with <= so all branches see the
    // pre-edge values; the Ack defaults below are overridden only by DONE.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state      <= IDLE;
            rem        <= '0;
            last       <= CLIENT1;
            Gen_Slt    <= CLIENT0;
            Gen_En     <= 1'b0;
            bus.Ack0   <= 1'b0;
            bus.Ack1   <= 1'b0;
            bus.Busy   <= 1'b0;
            bus.Result <= '0;
`ifdef CODE_SCHED_CLEAR_EN
            Gen_Reset  <= 1'b0;
`endif
        end else begin
            bus.Ack0 <= 1'b0;
            bus.Ack1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt_valid) begin
                        Gen_Slt  <= gnt_id;
                        last     <= gnt_id;
                        rem      <= gnt_cnt;
                        bus.Busy <= 1'b1;
`ifdef CODE_SCHED_CLEAR_EN
                        state     <= CLR;
                        Gen_Reset <= 1'b1;
`else
                        if (gnt_cnt == '0) begin
                            state <= DONE;
                        end else begin
                            state  <= RUN;
                            Gen_En <= 1'b1;
                        end
`endif
                    end
                end
`ifdef CODE_SCHED_CLEAR_EN
                CLR: begin
                    Gen_Reset <= 1'b0;
                    if (rem == '0) begin
                        state <= DONE;
                    end else begin
                        state  <= RUN;
                        Gen_En <= 1'b1;
                    end
                end
`endif
                RUN: begin
                    rem <= rem - CNT_W'(1);
                    if (rem == CNT_W'(1)) begin
                        state  <= DONE;
                        Gen_En <= 1'b0;
                    end
                end
                DONE: begin
                    bus.Result <= (Gen_Slt == CLIENT1) ? Gen_Out1 : Gen_Out0;
                    bus.Ack0   <= (Gen_Slt == CLIENT0);
                    bus.Ack1   <= (Gen_Slt == CLIENT1);
                    bus.Busy   <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_code_sched.sv
// Self-checking bench for code_sched: directed scenarios plus random traffic,
// compared every cycle against a job-timeline model of the scheduler.
`timescale 1ns/1ps
module tb_code_sched;
    import code_sched_pkg::*;

    localparam int DW = 64;
    localparam int CW = 8;
`ifdef CODE_SCHED_CLEAR_EN
    localparam int L = 1;
`else
    localparam int L = 0;
`endif
    localparam logic [63:0] BASE0 = 64'h0000_0000_0000_1000;
    localparam logic [63:0] STEP0 = 64'h0101_0101_0101_0101;
    localparam logic [63:0] BASE1 = 64'hF000_0000_0000_0000;
    localparam logic [63:0] STEP1 = 64'h0000_0003_0000_0007;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Gen_Slt, Gen_En, Gen_Reset;
    logic [63:0] g0 = BASE0;
    logic [63:0] g1 = BASE1;

    int n_total = 0;
    int n_pass  = 0;

    code_sched_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

    code_sched #(.DATA_W(DW), .CNT_W(CW)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .bus       (bus),
        .Gen_Slt   (Gen_Slt),
        .Gen_En    (Gen_En),
        .Gen_Reset (Gen_Reset),
        .Gen_Out0  (g0),
        .Gen_Out1  (g1)
    );

    always #5 Clk = ~Clk;

    // Stand-in generator: two arithmetic sequences, one stepped per enable.
    always @(posedge Clk) begin
        if (Gen_Reset === 1'b1) begin
            g0 <= BASE0;
            g1 <= BASE1;
        end else if (Gen_En === 1'b1) begin
            if (Gen_Slt) g1 <= g1 + STEP1;
            else         g0 <= g0 + STEP0;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [63:0] gval(input bit id, input longint k);
        return id ? BASE1 + 64'(k) * STEP1 : BASE0 + 64'(k) * STEP0;
    endfunction

    // Inputs as seen by the DUT at the most recent rising edge.
    logic       s_valid = 1'b0;
    logic       s_rst;
    logic [1:0] s_req;
    logic [7:0] s_cnt0, s_cnt1;

    always @(posedge Clk) begin
        s_valid <= 1'b1;
        s_rst   <= Reset;
        s_req   <= {bus.Req1, bus.Req0};
        s_cnt0  <= bus.Cnt0;
        s_cnt1  <= bus.Cnt1;
    end

    // Model: a job granted at edge e0 with count n has a fixed timeline
    // relative to e0; the generator is tracked as step counts per sequence.
    int          c = 0, d;
    bit          m_active = 0, m_id, m_last = 1, m_slt = 0;
    int          m_e0, m_n;
    logic [63:0] m_result = '0;
    longint      k0 = 0, k1 = 0;
    bit          prev_en = 0, prev_clr = 0, prev_slt = 0;
    bit          blk0, blk1, e0, e1, gid;
    bit          x_ack0, x_ack1, x_busy, x_en, x_clr, x_slt;
    logic [63:0] x_res;

    always @(negedge Clk) begin
        if (s_valid) begin
            c++;
            if (s_rst !== 1'b1) begin
                m_active = 0;
                m_last   = 1;
                m_slt    = 0;
                m_result = '0;
            end else begin
                blk0 = 0;
                blk1 = 0;
                if (m_active) begin
                    d = c - m_e0;
                    if (d == m_n + 1 + L) m_result = gval(m_id, m_id ? k1 : k0);
                    if (d == m_n + 2 + L) begin
                        m_active = 0;
                        if (m_id) blk1 = 1; else blk0 = 1;
                    end
                end
                if (!m_active) begin
                    e0 = s_req[0] && !blk0;
                    e1 = s_req[1] && !blk1;
                    if (e0 || e1) begin
                        // Both eligible: alternate away from the previous winner.
                        if (e0 && e1) gid = !m_last;
                        else          gid = e1;
                        m_active = 1;
                        m_e0     = c;
                        m_n      = gid ? int'(s_cnt1) : int'(s_cnt0);
                        m_id     = gid;
                        m_last   = gid;
                        m_slt    = gid;
                    end
                end
            end

            // Generator reaction to the control seen during the period just ended.
            if (prev_clr) begin
                k0 = 0;
                k1 = 0;
            end else if (prev_en) begin
                if (prev_slt) k1++; else k0++;
            end

            {x_ack0, x_ack1, x_busy, x_en, x_clr} = '0;
            x_slt = m_slt;
            x_res = m_result;
            if (m_active && s_rst === 1'b1) begin
                d      = c - m_e0;
                x_en   = (d >= L) && (d <= m_n - 1 + L);
                x_busy = (d <= m_n + L);
                x_clr  = (L == 1) && (d == 0);
                x_ack0 = (d == m_n + 1 + L) && !m_id;
                x_ack1 = (d == m_n + 1 + L) && m_id;
            end
            prev_en  = x_en;
            prev_clr = x_clr;
            prev_slt = x_slt;

            check($sformatf("ack0@%0d", c), 64'(bus.Ack0), 64'(x_ack0));
            check($sformatf("ack1@%0d", c), 64'(bus.Ack1), 64'(x_ack1));
            check($sformatf("busy@%0d", c), 64'(bus.Busy), 64'(x_busy));
            check($sformatf("gen_en@%0d", c), 64'(Gen_En), 64'(x_en));
            check($sformatf("gen_reset@%0d", c), 64'(Gen_Reset), 64'(x_clr));
            check($sformatf("gen_slt@%0d", c), 64'(Gen_Slt), 64'(x_slt));
            check($sformatf("result@%0d", c), bus.Result, x_res);
        end
    end

    task automatic run_single(input bit id, input int n, output int lat, output int ens,
                              output int acks, output logic slt);
        lat  = -1;
        ens  = 0;
        acks = 0;
        slt  = 1'bx;
        if (id) begin bus.Req1 = 1'b1; bus.Cnt1 = CW'(n); end
        else    begin bus.Req0 = 1'b1; bus.Cnt0 = CW'(n); end
        for (int i = 1; i <= n + 12; i++) begin
            @(negedge Clk);
            if (i == 1) begin
                bus.Cnt0 = 8'($urandom);
                bus.Cnt1 = 8'($urandom);
            end
            if (Gen_En) ens++;
            if (bus.Ack0 || bus.Ack1) begin
                acks++;
                if (lat < 0) begin lat = i; slt = Gen_Slt; end
                bus.Req0 = 1'b0;
                bus.Req1 = 1'b0;
            end
            if (lat > 0 && i >= lat + 2) break;
        end
        bus.Req0 = 1'b0;
        bus.Req1 = 1'b0;
    endtask

    function automatic logic [7:0] rand_cnt();
        return ($urandom_range(0, 79) == 0) ? 8'hFF : 8'($urandom_range(0, 6));
    endfunction

    int   lat, ens, acks, nack;
    logic slt;
    bit   order [4];

    initial begin
        Reset    = 1'b0;
        bus.Req0 = 1'b1;
        bus.Req1 = 1'b1;
        bus.Cnt0 = 8'd3;
        bus.Cnt1 = 8'd3;
        repeat (3) begin
            @(negedge Clk);
            check("rst_ack", 64'({bus.Ack1, bus.Ack0}), 64'd0);
            check("rst_busy", 64'(bus.Busy), 64'd0);
            check("rst_outs", 64'({Gen_En, Gen_Slt, Gen_Reset}), 64'd0);
            check("rst_result", bus.Result, 64'd0);
        end
        bus.Req0 = 1'b0;
        bus.Req1 = 1'b0;
        Reset    = 1'b1;
        @(negedge Clk);

        run_single(1'b0, 5, lat, ens, acks, slt);
        check("single_latency", 64'(lat), 64'(7 + L));
        check("single_en_cycles", 64'(ens), 64'd5);
        check("single_ack_count", 64'(acks), 64'd1);
        check("single_slt", 64'(slt), 64'd0);
        check("single_result", bus.Result, 64'h0505_0505_0505_1505);
        @(negedge Clk);

        run_single(1'b1, 0, lat, ens, acks, slt);
        check("zero_latency", 64'(lat), 64'(2 + L));
        check("zero_en_cycles", 64'(ens), 64'd0);
        check("zero_slt", 64'(slt), 64'd1);
        check("zero_result", bus.Result, 64'hF000_0000_0000_0000);
        @(negedge Clk);

        bus.Cnt0 = 8'd2;
        bus.Cnt1 = 8'd2;
        bus.Req0 = 1'b1;
        bus.Req1 = 1'b1;
        nack = 0;
        for (int i = 0; i < 80 && nack < 4; i++) begin
            @(negedge Clk);
            if (bus.Ack0 || bus.Ack1) begin
                order[nack] = bus.Ack1;
                check($sformatf("contend_slt%0d", nack), 64'(Gen_Slt), 64'(bus.Ack1));
                nack++;
            end
        end
        bus.Req0 = 1'b0;
        bus.Req1 = 1'b0;
        check("contend_acks", 64'(nack), 64'd4);
        check("contend_order", 64'({order[0], order[1], order[2], order[3]}), 64'b0101);
        @(negedge Clk);

        run_single(1'b0, 255, lat, ens, acks, slt);
        check("max_latency", 64'(lat), 64'(257 + L));
        check("max_en_cycles", 64'(ens), 64'd255);
        @(negedge Clk);

        bus.Req0 = 1'b1;
        bus.Cnt0 = 8'd10;
        ens = 0;
        for (int i = 0; i < 40 && ens < 3; i++) begin
            @(negedge Clk);
            if (Gen_En) ens++;
        end
        check("abort_run_seen", 64'(ens), 64'd3);
        Reset    = 1'b0;
        bus.Req0 = 1'b0;
        @(negedge Clk);
        check("abort_en", 64'(Gen_En), 64'd0);
        check("abort_ack", 64'({bus.Ack1, bus.Ack0}), 64'd0);
        check("abort_result", bus.Result, 64'd0);
        Reset = 1'b1;
        @(negedge Clk);
        run_single(1'b1, 1, lat, ens, acks, slt);
        check("post_abort_latency", 64'(lat), 64'(3 + L));
        check("post_abort_result", bus.Result,
              (L == 1) ? 64'hF000_0003_0000_0007 : 64'hF000_000F_0000_0023);

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge Clk);
            if (!Reset) Reset = 1'b1;
            else if ($urandom_range(0, 599) == 0) Reset = 1'b0;
            if (bus.Req0) begin
                if (bus.Ack0 && $urandom_range(0, 1) == 1) bus.Req0 = 1'b0;
            end else if ($urandom_range(0, 3) == 0) bus.Req0 = 1'b1;
            if (bus.Req1) begin
                if (bus.Ack1 && $urandom_range(0, 1) == 1) bus.Req1 = 1'b0;
            end else if ($urandom_range(0, 3) == 0) bus.Req1 = 1'b1;
            bus.Cnt0 = rand_cnt();
            bus.Cnt1 = rand_cnt();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/code_sched.md
# code_sched

Two-requester scheduler in front of the dual-sequence generator datapath (`Slt`/`En` control, two 64-bit outputs). It accepts step-count requests from two clients and grants the generator round-robin. For each grant it drives `Gen_Slt`/`Gen_En` for exactly the requested number of cycles, then returns the selected generator output with a one-cycle acknowledge. It sits between client logic and the generator instance and is the only driver of the generator's control inputs.

## Interface
- `DATA_W`, default 64: generator output and `Result` width.
- `CNT_W`, default 8: step-count width.
- `Clk` input, 1 bit: sole clock, rising edge.
- `Reset` input, 1 bit: synchronous, active-low reset.
- `Req0`, `Req1` input, 1 bit each: request from client 0/1; held high until the matching `Ack`.
- `Cnt0`, `Cnt1` input, `CNT_W` bits each: steps requested; sampled at grant.
- `Ack0`, `Ack1` output, 1 bit each: one-cycle completion pulse to client 0/1.
- `Result` output, `DATA_W` bits: captured generator output; valid while `Ack` is high and held afterwards.
- `Busy` output, 1 bit: high in every state except `IDLE`.
- `Gen_Slt` output, 1 bit: generator select; equals the granted client id.
- `Gen_En` output, 1 bit: generator step enable.
- `Gen_Reset` output, 1 bit: active-high generator clear pulse; see Configuration.
- `Gen_Out0`, `Gen_Out1` input, `DATA_W` bits: generator outputs.

## Operation
- States: `IDLE`, `CLR` (macro only), `RUN`, `DONE`.
- `IDLE`:
  - If any eligible `Req` is high, grant one, latch its id into `Gen_Slt` and its `Cnt` into the remaining-step counter `Rem`.
  - Next state is `CLR` if configured; otherwise `RUN`, or `DONE` when `Cnt == 0`.
- Arbitration:
  - Single request: granted.
  - Both high: grant the client not granted last time. The last-grant pointer resets to 1, so client 0 wins first.
  - A client whose `Ack` is high this cycle is ineligible this cycle.
- `RUN`:
  - `Gen_En = 1` and `Rem` decrements each cycle.
  - Exit to `DONE` at the edge where `Rem == 1`. Exactly `Cnt` enable cycles are produced.
- `DONE`:
  - `Gen_En = 0`.
  - At the edge: `Result <= Gen_Slt ? Gen_Out1 : Gen_Out0`, `Ack[id] <= 1`, next state `IDLE`.
- `Ack` clears after one cycle.
- `Req`/`Cnt` changes after grant are ignored until the next grant.
- `Gen_Slt` holds its last granted value in `IDLE`. `Gen_En` is 0 outside `RUN`.
- Reset values: state `IDLE`; `Ack0`/`Ack1`/`Busy`/`Gen_En`/`Gen_Reset`/`Gen_Slt` = 0; `Result` = 0; `Rem` = 0; pointer = 1.
- Reset mid-operation aborts immediately: no `Ack`, `Result` cleared, generator left un-stepped from that edge.
- `Cnt == 0`: no enable cycles; the current output is returned.
- `Cnt == 2^CNT_W−1`: full run with no wrap. `Rem` never underflows.

## Timing
- Request seen high in `IDLE` at edge E0, grant N:
  - `Gen_En` is high in cycles E0+1 … E0+N.
  - `DONE` occupies E0+N+1.
  - `Ack` is high in E0+N+2.
- Latency from request sample to `Ack` is N+2 cycles, or N+3 with `CLR`.
- Back-to-back: the other client can be granted in the `Ack` cycle. The same client needs `Req` low at least one cycle or is re-granted after its `Ack` cycle.
- All outputs are registered. No combinational path from inputs to outputs.

## Configuration
- Macro `CODE_SCHED_CLEAR_EN`.
- Defined: each grant passes through `CLR` for one cycle with `Gen_Reset = 1` and `Gen_En = 0`, so every job starts from the generator's initial sequence value. This adds one cycle of latency.
- Undefined: the `CLR` state is not compiled, `Gen_Reset` is tied to 0, and generator state carries over between jobs.

## Structure
- Package `code_sched_pkg` holds:
  - the state encoding (`IDLE`/`CLR`/`RUN`/`DONE`);
  - default `DATA_W`/`CNT_W` constants;
  - client-id constants (`CLIENT0 = 0`, `CLIENT1 = 1`).
- Sub-module `rr_arb2` is the 2-way round-robin picker, with inputs req[1:0], last and eligible mask, and outputs grant valid and id.
- FSM, counter and capture registers stay in `code_sched`.

## Test plan
- Reset: hold `Reset = 0` for 3 cycles with both `Req` high → all outputs 0, `Busy = 0`, no `Ack`.
- Single job: `Req0 = 1`, `Cnt0 = 5` → `Gen_Slt = 0`; `Gen_En` high exactly 5 cycles; `Ack0` pulses once 7 cycles after the sample edge (8 with macro); `Result == Gen_Out0` at `DONE`.
- Contention: `Req0` and `Req1` both high with `Cnt = 2` each, held → grant order 0, 1, 0, 1; `Ack` pulses alternate; `Gen_Slt` toggles per job.
- Zero count: `Req1 = 1`, `Cnt1 = 0` → no `Gen_En`; `Ack1` 2 cycles after sample; `Result = Gen_Out1` unchanged.
- Abort: `Reset` low in the 3rd `RUN` cycle of a `Cnt = 10` job → `Gen_En` 0 next cycle, no `Ack`, `Result = 0`, next request serviced normally.
- Macro on: two consecutive client-0 jobs, `Cnt = 3` → `Gen_Reset` pulses one cycle before each `RUN`; both `Result` values are equal.
